dcache_param: RTL and testbench
===============================

Name: dcache_param

Overview:
Parametrised successor to the 8-set data cache: direct-mapped, write-back, write-allocate data cache between the RV32IM MEM stage and data memory. Sets and block size are parameters. Adds byte-enable writes for SB/SH, a full refill/write-back FSM with a wide memory-block interface, and saturating hit/miss counters.

Parameters:
SETS, 8, number of cache lines (power of two, >=2); INDEX_W = log2(SETS)
WORDS_PER_BLOCK, 4, 32-bit words per line (power of two, >=1); OFFSET_W = log2(WORDS_PER_BLOCK)+2
ADDR_W, 32, byte-address width; TAG_W = ADDR_W-INDEX_W-OFFSET_W

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
READ  input  1  CPU load request
WRITE  input  1  CPU store request
BYTE_EN  input  4  store byte lanes; bit i enables WRITEDATA[8i+7:8i]
ADDRESS  input  ADDR_W  CPU byte address; bits [1:0] ignored
WRITEDATA  input  32  store data
READDATA  output  32  load data
BUSYWAIT  output  1  stall to CPU
MEM_READ  output  1  block fetch request
MEM_WRITE  output  1  block write-back request
MEM_ADDRESS  output  ADDR_W-OFFSET_W  block address {tag,index}
MEM_WRITEDATA  output  32*WORDS_PER_BLOCK  victim block, word 0 in LSBs
MEM_READDATA  input  32*WORDS_PER_BLOCK  fetched block, word 0 in LSBs
MEM_BUSYWAIT  input  1  memory busy; transfer completes on a rising edge with request high and MEM_BUSYWAIT low
HIT_COUNT  output  32  saturating hit counter
MISS_COUNT  output  32  saturating miss counter

Behaviour:
- Address split: offset word = ADDRESS[OFFSET_W-1:2], index = ADDRESS[OFFSET_W+INDEX_W-1:OFFSET_W], tag = upper TAG_W bits.
- hit = valid[index] && tag[index]==tag. Evaluated combinationally.
- Reset (RESET low, asynchronous): all valid and dirty bits 0; state IDLE; MEM_READ=MEM_WRITE=0; BUSYWAIT=0; counters 0. READDATA = 0 while reset is low. Data/tag arrays are not cleared. Reset during WRITEBACK or FETCH abandons the transfer; the dirty victim is lost. This is the defined behaviour.
- States: IDLE, WRITEBACK, FETCH, FILL.
- IDLE, no request: BUSYWAIT=0.
- IDLE, READ hit: READDATA = addressed word, combinationally in the same cycle; BUSYWAIT=0.
- IDLE, WRITE hit: enabled bytes are written at the rising edge; dirty=1; BUSYWAIT=0.
- IDLE, miss (READ|WRITE): BUSYWAIT=1 combinationally in the same cycle. At the next edge go to WRITEBACK if valid&&dirty, else FETCH.
- WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line. Go to FETCH on the completing edge.
- FETCH: MEM_READ=1, MEM_ADDRESS={request tag,index}. On the completing edge, latch MEM_READDATA into the line and go to FILL.
- FILL: write tag; set valid=1, dirty=0. BUSYWAIT=1. Next state IDLE; the held request then hits and completes.
- BUSYWAIT is 1 in every non-IDLE state. The CPU holds READ, WRITE, ADDRESS, WRITEDATA and BYTE_EN stable while BUSYWAIT=1.
- MEM_READ and MEM_WRITE are never both 1. Both are 0 in IDLE and FILL.
- READ and WRITE both high: treated as a write. READDATA shows the pre-write word.
- Write with BYTE_EN=0000: normal write semantics (allocates on miss, sets dirty); data is unchanged.
- Counters: MISS_COUNT +1 on each IDLE->WRITEBACK/FETCH edge. HIT_COUNT +1 on each IDLE edge with a hitting request, except the first IDLE cycle after FILL (the replay). Both saturate at 0xFFFF_FFFF.
- Latency: hit 0 stall cycles. Clean miss = 1 (IDLE) + FETCH cycles + 1 (FILL) stall cycles. Dirty miss adds the WRITEBACK cycles.

Test Plan:
(defaults: SETS=8, WORDS=4; index=ADDRESS[6:4])
- Reset, then READ 0x0000_0014. Memory holds 2 busy cycles and returns block {W3..W0}={4,3,2,1}. -> BUSYWAIT high through FETCH(3 cycles)+FILL; MEM_ADDRESS=0x000_0001; READDATA=0x2 in the replay cycle; MISS_COUNT=1, HIT_COUNT=0.
- Then WRITE 0x0000_0014, WRITEDATA 0xDEAD_BEEF, BYTE_EN 0011 -> no BUSYWAIT. Then READ 0x14 -> READDATA=0x0000_BEEF; HIT_COUNT=2.
- Then READ 0x0000_0094 (index 1, different tag, line dirty) -> WRITEBACK with MEM_ADDRESS 0x000_0001 and MEM_WRITEDATA word1=0x0000_BEEF, then FETCH with MEM_ADDRESS 0x000_0009; dirty cleared after FILL.
- Write miss to clean set 2 (ADDRESS 0x24, BYTE_EN 1111, data 0xA5A5_A5A5) -> FETCH only, no WRITEBACK; afterwards the line is dirty and READ 0x24 returns 0xA5A5_A5A5.
- RESET driven low in the second FETCH cycle -> MEM_READ and BUSYWAIT drop immediately; after release, the same READ misses again (valid=0); counters are 0.
- READ and WRITE both high on a hit to 0x24 with data 0x1 -> READDATA=0xA5A5_A5A5 that cycle; subsequent read returns 0x1.

Source files
------------

// File: rtl/dcache_param.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// block-wide data memory, with byte-enable stores and saturating hit/miss counters.
module dcache_param #(
  parameter int SETS            = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_W          = 32,
  localparam int INDEX_W  = $clog2(SETS),
  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK) + 2,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int BLOCK_W  = 32 * WORDS_PER_BLOCK
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [3:0]                 BYTE_EN,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [31:0]                WRITEDATA,
  output logic [31:0]                READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT,
  output logic [31:0]                HIT_COUNT,
  output logic [31:0]                MISS_COUNT,
  output logic [1:0]                 dbg_state
);

  localparam int WORD_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      data_q [SETS][WORDS_PER_BLOCK];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic             replay_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [WORD_W-1:0]  req_word;
  logic               addr_unused;
  logic               req;
  logic               hit;
  logic [31:0]        cur_word;
  logic               wr_hit_en;
  logic               fill_en;
  logic               hit_evt;
  logic               miss_evt;

  assign req_tag     = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_index   = ADDRESS[OFFSET_W +: INDEX_W];
  assign addr_unused = ^ADDRESS[1:0];

  generate
    if (WORDS_PER_BLOCK > 1) begin : g_multi_word
      assign req_word = ADDRESS[2 +: WORD_W];
    end else begin : g_single_word
      assign req_word = '0;
    end
  endgenerate

  assign req      = READ | WRITE;
  assign hit      = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign cur_word = data_q[req_index][req_word];

  // Stores land only from IDLE on a hit, including the replay cycle after FILL.
  assign wr_hit_en = (state_q == S_IDLE) && WRITE && hit;
  assign fill_en   = (state_q == S_FETCH) && !MEM_BUSYWAIT;
  assign hit_evt   = (state_q == S_IDLE) && req && hit && !replay_q;
  assign miss_evt  = (state_q == S_IDLE) && req && !hit;

  // Memory handshake: MEM_READ/MEM_WRITE act as valid and stay high for the whole
  // transfer; the transfer completes on the rising edge where the request is high
  // and MEM_BUSYWAIT (inverse ready) is low. The CPU side holds its request while
  // BUSYWAIT is high and sees completion as the first cycle with BUSYWAIT low.

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[req_index] && dirty_q[req_index]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        if (!MEM_BUSYWAIT) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!MEM_BUSYWAIT) state_d = S_FILL;
      end
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = {req_tag, req_index};
    BUSYWAIT    = 1'b0;
    READDATA    = '0;
    case (state_q)
      S_IDLE: begin
        BUSYWAIT = req && !hit;
        if (READ && hit) READDATA = cur_word;
      end
      S_WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        BUSYWAIT    = 1'b1;
        MEM_ADDRESS = {tag_q[req_index], req_index};
      end
      S_FETCH: begin
        MEM_READ = 1'b1;
        BUSYWAIT = 1'b1;
      end
      S_FILL:  BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
    // Reset silences the CPU-facing outputs even while a request is still held.
    if (!RESET) begin
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      BUSYWAIT  = 1'b0;
      READDATA  = '0;
    end
  end

  always_comb begin
    MEM_WRITEDATA = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      MEM_WRITEDATA[32*w +: 32] = data_q[req_index][w];
    end
  end

  // Data and tag arrays are deliberately left out of reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        data_q[req_index][w] <= MEM_READDATA[32*w +: 32];
      end
    end else if (wr_hit_en) begin
      for (int b = 0; b < 4; b++) begin
        if (BYTE_EN[b]) data_q[req_index][req_word][8*b +: 8] <= WRITEDATA[8*b +: 8];
      end
    end
    if (state_q == S_FILL) tag_q[req_index] <= req_tag;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == S_FILL) begin
      valid_q[req_index] <= 1'b1;
      dirty_q[req_index] <= 1'b0;
    end else if (wr_hit_en) begin
      dirty_q[req_index] <= 1'b1;
    end
  end

  // The first IDLE cycle after FILL finishes the stalled request and is not a new hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == S_FILL);
      if (hit_evt && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dcache_param.sv
// Bench for dcache_param: directed scenarios then random loads/stores, checked
// against a set-level cache model and a block memory with configurable latency.
module tb_dcache_param;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read, write;
  logic [3:0]    byte_en;
  logic [31:0]   address, writedata, readdata;
  logic          busywait, mem_read, mem_write, mem_busywait;
  logic [27:0]   mem_address;
  logic [127:0]  mem_writedata, mem_readdata;
  logic [31:0]   hit_count, miss_count;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  dcache_param #(.SETS(8), .WORDS_PER_BLOCK(4), .ADDR_W(32)) dut (
    .CLK(clk), .RESET(rst_n), .READ(read), .WRITE(write), .BYTE_EN(byte_en),
    .ADDRESS(address), .WRITEDATA(writedata), .READDATA(readdata),
    .BUSYWAIT(busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata),
    .MEM_READDATA(mem_readdata), .MEM_BUSYWAIT(mem_busywait),
    .HIT_COUNT(hit_count), .MISS_COUNT(miss_count), .dbg_state(dbg_state)
  );

  // block memory seen by the DUT, and the bench's own expectation of it
  logic [127:0] mem     [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];
  int mem_lat  = 0;
  int busy_cnt = 0;

  function automatic logic [127:0] blk_default(input logic [27:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = {4'h5, a} ^ (32'h0101_0101 * 32'(w));
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (mem_read || mem_write)) begin
      if (busy_cnt < mem_lat) begin
        mem_busywait = 1'b1;
        busy_cnt++;
      end else begin
        mem_busywait = 1'b0;
        busy_cnt = 0;
        if (mem_write) mem[mem_address] = mem_writedata;
      end
    end else begin
      mem_busywait = 1'b0;
      busy_cnt = 0;
    end
    mem_readdata = mem.exists(mem_address) ? mem[mem_address] : blk_default(mem_address);
  end

  // cache model: one entry per set
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [24:0] m_tag   [8];
  logic [31:0] m_word  [8][4];
  int          m_hits, m_misses;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one CPU access held until BUSYWAIT drops, then one more edge to retire it
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int lat);
    int idx, w, stalls, wb_cyc, fe_cyc, exp_stalls;
    logic [24:0]  tag;
    bit           hit, wb;
    logic [27:0]  wb_addr, fe_addr;
    logic [127:0] wb_blk, blk;
    logic [31:0]  exp_rd;

    idx = int'((addr >> 4) % 32'd8);
    w   = int'((addr >> 2) % 32'd4);
    tag = 25'(addr >> 7);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr = {m_tag[idx], 3'(idx)};
    fe_addr = {tag, 3'(idx)};
    for (int k = 0; k < 4; k++) wb_blk[32*k +: 32] = m_word[idx][k];
    exp_stalls = hit ? 0 : 2 + (lat + 1) + (wb ? lat + 1 : 0);

    if (!hit) begin
      if (wb) ref_mem[wb_addr] = wb_blk;
      blk = ref_mem.exists(fe_addr) ? ref_mem[fe_addr] : blk_default(fe_addr);
      for (int k = 0; k < 4; k++) m_word[idx][k] = blk[32*k +: 32];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_misses++;
    end else begin
      m_hits++;
    end
    exp_rd = m_word[idx][w];
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_word[idx][w][8*b +: 8] = wdata[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end

    mem_lat = lat;
    read = rd; write = wr; address = addr; writedata = wdata; byte_en = be;
    stalls = 0; wb_cyc = 0; fe_cyc = 0;
    #1;
    while (busywait && stalls < 100) begin
      stalls++;
      check("mem_req_exclusive", 128'(mem_read & mem_write), 128'(0));
      if (mem_write) begin
        if (wb_cyc == 0) begin
          check("wb_address", 128'(mem_address), 128'(wb_addr));
          check("wb_data", mem_writedata, wb_blk);
        end
        wb_cyc++;
      end
      if (mem_read) begin
        if (fe_cyc == 0) check("fetch_address", 128'(mem_address), 128'(fe_addr));
        fe_cyc++;
      end
      @(negedge clk); #1;
    end
    check("stall_cycles", 128'(stalls), 128'(exp_stalls));
    check("wb_cycles", 128'(wb_cyc), 128'(wb ? lat + 1 : 0));
    check("fetch_cycles", 128'(fe_cyc), 128'(hit ? 0 : lat + 1));
    if (rd) check("readdata", 128'(readdata), 128'(exp_rd));
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    #1;
    check("hit_count", 128'(hit_count), 128'(m_hits));
    check("miss_count", 128'(miss_count), 128'(m_misses));
  endtask

  initial begin
    rst_n = 1'b0;
    read = 1'b1; write = 1'b0; byte_en = 4'h0; address = 32'h14; writedata = '0;
    mem_busywait = 1'b0; mem_readdata = '0;
    model_reset();
    mem[28'h1]     = {32'd4, 32'd3, 32'd2, 32'd1};
    ref_mem[28'h1] = {32'd4, 32'd3, 32'd2, 32'd1};

    // reset state, with a load held on the bus
    repeat (2) @(negedge clk);
    #1;
    check("rst_busywait", 128'(busywait), 128'(0));
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_readdata", 128'(readdata), 128'(0));
    check("rst_hit_count", 128'(hit_count), 128'(0));
    check("rst_miss_count", 128'(miss_count), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clean read miss, then store/load hits on the same line
    access(1, 0, 32'h0000_0014, 32'h0, 4'h0, 2);
    access(0, 1, 32'h0000_0014, 32'hDEAD_BEEF, 4'b0011, 2);
    access(1, 0, 32'h0000_0014, 32'h0, 4'h0, 2);
    // dirty conflict miss forces write-back, then the clean line is evicted silently
    access(1, 0, 32'h0000_0094, 32'h0, 4'h0, 1);
    access(1, 0, 32'h0000_0014, 32'h0, 4'h0, 1);
    // write-allocate into a clean set
    access(0, 1, 32'h0000_0024, 32'hA5A5_A5A5, 4'b1111, 2);
    access(1, 0, 32'h0000_0024, 32'h0, 4'h0, 2);
    // READ and WRITE together: load sees the pre-store word
    access(1, 1, 32'h0000_0024, 32'h0000_0001, 4'b1111, 2);
    access(1, 0, 32'h0000_0024, 32'h0, 4'h0, 2);
    // empty byte mask: no data change, but allocation and dirty marking still happen
    access(0, 1, 32'h0000_0028, 32'hFFFF_FFFF, 4'b0000, 0);
    access(1, 0, 32'h0000_0028, 32'h0, 4'h0, 0);
    access(0, 1, 32'h0000_01A8, 32'hFFFF_FFFF, 4'b0000, 1);
    access(1, 0, 32'h0000_0024, 32'h0, 4'h0, 1);

    // reset dropped during the second fetch cycle
    mem_lat = 3; read = 1'b1; write = 1'b0; address = 32'h0000_0054;
    #1;
    check("rstfetch_busy_idle", 128'(busywait), 128'(1));
    @(negedge clk); #1;
    check("rstfetch_cycle1", 128'(mem_read), 128'(1));
    @(negedge clk); #1;
    check("rstfetch_cycle2", 128'(mem_read), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rstfetch_mem_read", 128'(mem_read), 128'(0));
    check("rstfetch_busywait", 128'(busywait), 128'(0));
    check("rstfetch_readdata", 128'(readdata), 128'(0));
    check("rstfetch_hit_count", 128'(hit_count), 128'(0));
    check("rstfetch_miss_count", 128'(miss_count), 128'(0));
    check("rstfetch_state", 128'(dbg_state), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 32'h0000_0054, 32'h0, 4'h0, 2);
    access(1, 0, 32'h0000_0014, 32'h0, 4'h0, 0);

    // random loads/stores over 4 tags x 8 sets
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int op;
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      access(op != 2, op >= 2, a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
